// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scanner: tear-free double-buffered digits, 16-level PWM dimming.
// Define SEG_BLINK_EN to add per-digit blinking; without it blink_mask is accepted and ignored.
module seg_scan_driver #(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 100_000,
    parameter int BLINK_FRAMES = 250
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   digit_val,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic                  load,
    input  logic [3:0]            brightness,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frame_start,
    output logic                  pending
);

    localparam int SUB_DIV = SCAN_DIV / 16;
    localparam int SUB_W   = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SUB_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    typedef struct packed {
        logic [4*DIGITS-1:0] val;
        logic [DIGITS-1:0]   en;
        logic [DIGITS-1:0]   dp;
    } disp_set_t;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // The slot counter is split into a PWM sub-phase (upper) and a prescaler (lower),
    // so sub = slot / (SCAN_DIV/16) needs no divider.
    logic [SUB_W-1:0] sub_cnt;
    logic [3:0]       sub;
    logic [IDX_W-1:0] idx;
    logic             sub_last;
    logic             slot_last;
    logic             boundary;

    assign sub_last  = (sub_cnt == SUB_LAST);
    assign slot_last = sub_last && (sub == 4'hF);
    assign boundary  = slot_last && (idx == IDX_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            sub_cnt <= '0;
            sub     <= '0;
            idx     <= '0;
        end else begin
            if (sub_last) begin
                sub_cnt <= '0;
                sub     <= sub + 4'd1;
            end else begin
                sub_cnt <= sub_cnt + SUB_W'(1);
            end
            if (slot_last) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            end
        end
    end

    disp_set_t in_set;
    disp_set_t staging;
    disp_set_t active;

    assign in_set = '{val: digit_val, en: digit_en, dp: dp_in};

    // NOTE: both display sets are reset so the panel stays dark until the first load.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            staging <= '0;
            active  <= '0;
            pending <= 1'b0;
        end else if (boundary) begin
            if (load) begin
                active <= in_set;
            end else if (pending) begin
                active <= staging;
            end
            pending <= 1'b0;
        end else if (load) begin
            staging <= in_set;
            pending <= 1'b1;
        end
    end

    logic [DIGITS-1:0] blank_mask;

`ifdef SEG_BLINK_EN
    localparam int BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BF_W-1:0] BF_LAST = BF_W'(BLINK_FRAMES - 1);

    logic [BF_W-1:0]   blink_cnt;
    logic              blink_phase;
    logic [DIGITS-1:0] blink_stg;
    logic [DIGITS-1:0] blink_act;

    // Blink masks follow the same staging/active path as the digits; the phase
    // only changes on frame boundaries so a digit never blinks mid-frame.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            blink_stg   <= '0;
            blink_act   <= '0;
        end else if (boundary) begin
            if (load) begin
                blink_act <= blink_mask;
            end else if (pending) begin
                blink_act <= blink_stg;
            end
            if (blink_cnt == BF_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + BF_W'(1);
            end
        end else if (load) begin
            blink_stg <= blink_mask;
        end
    end

    assign blank_mask = blink_phase ? blink_act : '0;
`else
    logic unused_blink;

    assign unused_blink = ^blink_mask;
    assign blank_mask   = '0;
`endif

    logic pwm_on;
    logic lit;
    logic boundary_d;

    assign pwm_on = (sub < brightness);
    assign lit    = active.en[idx] && pwm_on && !blank_mask[idx];

    // frame_start is delayed twice: once to reach the first digit-0 state, once more
    // to line up with the registered pins.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            an          <= '1;
            seg         <= 7'h7F;
            dp          <= 1'b1;
            boundary_d  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            boundary_d  <= boundary;
            frame_start <= boundary_d;
            if (lit) begin
                an  <= ~(DIGITS'(1) << idx);
                seg <= decode(active.val[idx*4 +: 4]);
                dp  <= ~active.dp[idx];
            end else begin
                an  <= '1;
                seg <= 7'h7F;
                dp  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: vector table of loads, scoreboard of per-digit
// expectations checked cycle by cycle over whole frames, plus reset/pending/boundary/blink sequences.
module tb_seg_scan_driver;

    localparam int DIGITS       = 4;
    localparam int SCAN_DIV     = 32;
    localparam int BLINK_FRAMES = 2;
    localparam int FIRST_FS     = 129;

    logic        clock = 1'b0;
    logic        rst;
    logic [15:0] digit_val;
    logic [3:0]  digit_en;
    logic [3:0]  dp_in;
    logic [3:0]  blink_mask;
    logic        load;
    logic [3:0]  brightness;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_start;
    logic        pending;

    always #5 clock = ~clock;

    seg_scan_driver #(
        .DIGITS       (DIGITS),
        .SCAN_DIV     (SCAN_DIV),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .clock       (clock),
        .rst         (rst),
        .digit_val   (digit_val),
        .digit_en    (digit_en),
        .dp_in       (dp_in),
        .blink_mask  (blink_mask),
        .load        (load),
        .brightness  (brightness),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .frame_start (frame_start),
        .pending     (pending)
    );

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        int         lit_cycles;
    } exp_digit_t;

    typedef struct {
        logic [15:0] val;
        logic [3:0]  en;
        logic [3:0]  dpv;
        logic [3:0]  bright;
    } vec_t;

    exp_digit_t sb_q[$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic push_expect(input logic [15:0] val, input logic [3:0] en, input logic [3:0] dpv,
                               input logic [3:0] bright, input logic [3:0] blanked);
        for (int d = 0; d < 4; d++) begin
            exp_digit_t e;
            logic [3:0] nib;
            nib          = val[d*4 +: 4];
            e.an         = ~(4'b0001 << d);
            e.seg        = seg_tab[nib];
            e.dp         = ~dpv[d];
            e.lit_cycles = (en[d] && !blanked[d]) ? 2 * int'(bright) : 0;
            sb_q.push_back(e);
        end
    endtask

    task automatic wait_frame_start(output bit found);
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (frame_start === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic sync_mid_frame(input string tag);
        bit found;
        wait_frame_start(found);
        check($sformatf("%s sync frame_start seen", tag), found, 1);
        repeat (10) @(negedge clock);
    endtask

    task automatic apply_load(input logic [15:0] val, input logic [3:0] en, input logic [3:0] dpv,
                              input logic [3:0] bmask, input logic [3:0] bright);
        digit_val  = val;
        digit_en   = en;
        dp_in      = dpv;
        blink_mask = bmask;
        brightness = bright;
        load       = 1'b1;
        @(negedge clock);
        load = 1'b0;
    endtask

    // Waits for the next frame and compares every cycle of each digit slot against the scoreboard.
    task automatic sample_frame(input string tag);
        bit found;
        wait_frame_start(found);
        check($sformatf("%s frame_start seen", tag), found, 1);
        if (!found) return;
        check($sformatf("%s pending at frame_start", tag), pending, 0);
        for (int d = 0; d < 4; d++) begin
            exp_digit_t e;
            int lit_seen;
            int bad;
            int bad_c;
            logic [12:0] got;
            logic [12:0] want;
            logic [12:0] bad_got;
            logic [12:0] bad_want;
            if (sb_q.size() == 0) begin
                check($sformatf("%s scoreboard underflow", tag), 0, 1);
                return;
            end
            e        = sb_q.pop_front();
            lit_seen = 0;
            bad      = 0;
            bad_c    = 0;
            bad_got  = '0;
            bad_want = '0;
            for (int c = 0; c < SCAN_DIV; c++) begin
                bit on;
                if (!(d == 0 && c == 0)) @(negedge clock);
                on   = (c < e.lit_cycles);
                want = {on ? e.an : 4'hF, on ? e.seg : 7'h7F, on ? e.dp : 1'b1, (d == 0 && c == 0)};
                got  = {an, seg, dp, frame_start};
                if (an === e.an) lit_seen++;
                if (got !== want) begin
                    if (bad == 0) begin
                        bad_c    = c;
                        bad_got  = got;
                        bad_want = want;
                    end
                    bad++;
                end
            end
            check($sformatf("%s digit%0d lit cycles", tag, d), lit_seen, e.lit_cycles);
            check($sformatf("%s digit%0d bad cycles", tag, d), bad, 0);
            if (bad != 0)
                $display("  %s digit%0d first divergence at cycle %0d: pins {an,seg,dp,fs}=%h want %h",
                         tag, d, bad_c, bad_got, bad_want);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   n;
        bit   found;

        vecs[0] = '{val: 16'h1A3F, en: 4'hF,    dpv: 4'b0000, bright: 4'd15};
        vecs[1] = '{val: 16'h4567, en: 4'hF,    dpv: 4'b0101, bright: 4'd8};
        vecs[2] = '{val: 16'h89BC, en: 4'b1011, dpv: 4'b0001, bright: 4'd15};
        vecs[3] = '{val: 16'hDE02, en: 4'hF,    dpv: 4'b1000, bright: 4'd4};
        vecs[4] = '{val: 16'h1A3F, en: 4'hF,    dpv: 4'b1111, bright: 4'd0};
        vecs[5] = '{val: 16'h5A9E, en: 4'hF,    dpv: 4'b0010, bright: 4'd1};

        rst        = 1'b1;
        load       = 1'b0;
        digit_val  = '0;
        digit_en   = '0;
        dp_in      = '0;
        blink_mask = '0;
        brightness = 4'd15;

        repeat (3) @(negedge clock);
        check("reset an", an, 4'hF);
        check("reset seg", seg, 7'h7F);
        check("reset dp", dp, 1'b1);
        check("reset frame_start", frame_start, 1'b0);
        check("reset pending", pending, 1'b0);

        rst = 1'b0;
        n = 0;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clock);
            if (frame_start === 1'b1) begin
                n = i;
                break;
            end
        end
        check("first frame_start latency", n, FIRST_FS);

        push_expect(16'h0000, 4'h0, 4'h0, 4'd15, 4'h0);
        sample_frame("blank after reset");

        for (int v = 0; v < 6; v++) begin
            sync_mid_frame($sformatf("vec%0d", v));
            apply_load(vecs[v].val, vecs[v].en, vecs[v].dpv, 4'h0, vecs[v].bright);
            check($sformatf("vec%0d pending after load", v), pending, 1);
            push_expect(vecs[v].val, vecs[v].en, vecs[v].dpv, vecs[v].bright, 4'h0);
            sample_frame($sformatf("vec%0d", v));
        end

        sync_mid_frame("two loads");
        apply_load(16'h7777, 4'hF, 4'h0, 4'h0, 4'd12);
        check("two loads pending first", pending, 1);
        repeat (20) @(negedge clock);
        apply_load(16'h2C5E, 4'hF, 4'b0100, 4'h0, 4'd12);
        check("two loads pending second", pending, 1);
        push_expect(16'h2C5E, 4'hF, 4'b0100, 4'd12, 4'h0);
        sample_frame("two loads");

        wait_frame_start(found);
        check("boundary sync frame_start seen", found, 1);
        repeat (126) @(negedge clock);
        check("boundary pending before load", pending, 0);
        apply_load(16'hB3D0, 4'hF, 4'b0100, 4'h0, 4'd15);
        check("boundary load pending", pending, 0);
        push_expect(16'hB3D0, 4'hF, 4'b0100, 4'd15, 4'h0);
        sample_frame("boundary load");

        sync_mid_frame("mid reset");
        check("mid reset digit0 lit before", an, 4'hE);
        apply_load(16'h6666, 4'hF, 4'h0, 4'h0, 4'd15);
        check("mid reset pending before", pending, 1);
        #2 rst = 1'b1;
        #1;
        check("mid reset an", an, 4'hF);
        check("mid reset seg", seg, 7'h7F);
        check("mid reset dp", dp, 1'b1);
        check("mid reset pending", pending, 0);
        check("mid reset frame_start", frame_start, 0);
        @(negedge clock);
        rst = 1'b0;
        n = 0;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clock);
            if (frame_start === 1'b1) begin
                n = i;
                break;
            end
        end
        check("restart frame_start latency", n, FIRST_FS);
        push_expect(16'h0000, 4'h0, 4'h0, 4'd15, 4'h0);
        sample_frame("staging discarded");

`ifdef SEG_BLINK_EN
        rst = 1'b1;
        @(negedge clock);
        rst = 1'b0;
        repeat (10) @(negedge clock);
        apply_load(16'h1A3F, 4'hF, 4'h0, 4'b0001, 4'd15);
        push_expect(16'h1A3F, 4'hF, 4'h0, 4'd15, 4'b0000);
        push_expect(16'h1A3F, 4'hF, 4'h0, 4'd15, 4'b0001);
        push_expect(16'h1A3F, 4'hF, 4'h0, 4'd15, 4'b0001);
        push_expect(16'h1A3F, 4'hF, 4'h0, 4'd15, 4'b0000);
        push_expect(16'h1A3F, 4'hF, 4'h0, 4'd15, 4'b0000);
        for (int f = 1; f <= 5; f++) sample_frame($sformatf("blink frame%0d", f));
`else
        sync_mid_frame("blink ignored");
        apply_load(16'h1A3F, 4'hF, 4'h0, 4'hF, 4'd15);
        push_expect(16'h1A3F, 4'hF, 4'h0, 4'd15, 4'h0);
        push_expect(16'h1A3F, 4'hF, 4'h0, 4'd15, 4'h0);
        sample_frame("blink ignored frame1");
        sample_frame("blink ignored frame2");
`endif

        check("scoreboard drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Parametrised multiplexed seven-segment scanner that generalises the board's fixed 4-digit display driver to DIGITS digits. It latches new hex values without tearing, with per-digit blanking and decimal points, 16-level PWM brightness and optional blink. It sits between the task/status logic (audio level, valid number, mode) and the an/seg/dp pins.

## Interface
- DIGITS, 4: number of digits scanned; 1..8.
- SCAN_DIV, 100_000: clock cycles per digit slot; multiple of 16, ≥16.
- BLINK_FRAMES, 250: frames per blink half-period; ≥1.
- clock  in  1  system clock (100 MHz on board).
- rst  in  1  reset, asynchronous, active-high.
- digit_val  in  4*DIGITS  hex nibble per digit; digit i = bits [4i+3:4i].
- digit_en  in  DIGITS  1 = digit shown, 0 = digit blanked.
- dp_in  in  DIGITS  1 = decimal point lit for digit i.
- blink_mask  in  DIGITS  1 = digit blinks; ignored without SEG_BLINK_EN.
- load  in  1  one-cycle strobe; captures digit_val/digit_en/dp_in/blink_mask.
- brightness  in  4  PWM level 0..15; sampled continuously.
- an  out  DIGITS  anodes, active-low.
- seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- frame_start  out  1  one-cycle pulse when the scan wraps to digit 0.
- pending  out  1  captured values waiting for the next frame boundary.

## Operation
- Registers: a staging set captured on load, and an active set used for display.
- Slot counter counts 0..SCAN_DIV-1. On its terminal count the digit index advances by 1 modulo DIGITS.
- Frame boundary: the cycle where slot counter and index both wrap to 0.
  - frame_start pulses for that cycle.
  - If pending is set, staging is copied to active and pending clears.
- load outside a boundary cycle: staging is overwritten and pending is set. The last load wins.
- load on a boundary cycle: inputs go straight to active and pending stays 0.
- Sub-phase: sub = slot_cnt / (SCAN_DIV/16), range 0..15.
  - The current digit is driven only when sub < brightness.
  - brightness 0 gives a fully dark display; brightness 15 gives a 15/16 duty cycle.
- Digit i is lit when: index == i, digit_en[i] = 1, the PWM is on, and the digit is not blink-suppressed.
  - When lit: an[i] = 0, seg = decode(val), dp = ~dp_in[i].
  - Otherwise: an = all 1, seg = 7'h7F, dp = 1.
- Decode table (seg, active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Reset values:
  - an all 1, seg 7'h7F, dp 1, frame_start 0, pending 0.
  - Index 0 and all counters 0.
  - Active and staging sets all 0, so every digit is blanked.
  - Blink phase 0.
- An asserted rst mid-frame forces the reset values immediately and discards the staging set. Scanning restarts at digit 0, slot 0 after release.

## Timing
- an, seg and dp are registered: one cycle of latency from the index/slot/active state to the pins.
- frame_start is registered with the same one-cycle latency, so it is aligned with digit 0's first output cycle.
- A load is visible on the pins by at most DIGITS*SCAN_DIV+1 cycles after the strobe.
- Anode transitions occur only at slot boundaries or PWM edges. There is never more than one an bit low at a time.
- Frame period is DIGITS*SCAN_DIV cycles. With the defaults that is 4 ms (250 Hz).
- A brightness change takes effect on the next cycle's PWM comparison.

## Configuration
- SEG_BLINK_EN defined:
  - A frame counter counts 0..BLINK_FRAMES-1 on frame_start and toggles the blink phase on wrap.
  - Digits with active blink_mask = 1 are blanked while the phase is 1.
  - Reset sets the phase to 0, so digits are visible first.
- SEG_BLINK_EN undefined:
  - No blink counter exists and blink_mask is ignored.
  - The port remains, so the interface is unchanged.

## Test plan
Bench parameters: DIGITS=4, SCAN_DIV=32, BLINK_FRAMES=2.
- Reset, then load digit_val=16'h1A3F, digit_en=4'hF, brightness=15 -> after the first boundary, digits 0..3 show seg 0E, 30, 08, 79 with an 1110, 1101, 1011, 0111. Each digit is lit for 30 of its 32 cycles.
- load mid-frame -> pending=1 until the frame_start cycle, then 0. The displayed values change exactly at digit 0 of the next frame. Two loads in one frame -> only the second appears.
- load on the boundary cycle -> pending stays 0 and the new value is shown at that frame's digit 0.
- brightness=4 -> each digit's an is low for 8 of its 32 cycles. brightness=0 -> an stays 4'hF.
- digit_en=4'b1011, dp_in=4'b0001 -> digit 2 slot shows an=F and seg=7F. dp=0 only in the digit 0 slot.
- With SEG_BLINK_EN, blink_mask=4'b0001 -> digit 0 is visible for 2 frames, blank for 2 frames, and so on. rst asserted mid-slot -> an=F and seg=7F on the next cycle, and pending=0.
